pixel_shader: RTL and testbench

//  Downstream colour stage between the sprite/layer address mux and the VGA pins.

---
 rtl/pixel_shader.sv | 129 ++++++++++++
 tb/tb_pixel_shader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_shader.sv
// pixel_shader: ROM colour fetch with colour key, dark-mode vision mask and a frame fade on game-state change
module pixel_shader #(
  parameter int MEM_LAT = 2,
  parameter logic [11:0] KEY_COLOR = 12'h0F0,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [8:0] DARK_HALF = 9'd40,
  parameter int FRM_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [16:0] pixel_addr,
  input  logic        not_blank,
  input  logic        is_dark,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [3:0]  state_in,
  output logic [16:0] mem_addr,
  input  logic [11:0] mem_rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        fade_busy
);
  localparam int D = MEM_LAT + 1;
  localparam int CW = FRM_STEP > 1 ? $clog2(FRM_STEP) : 1;
  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} fade_t;
  fade_t fsm;
  logic [D-1:0] v_d, nb_d, dim_d, hs_d, vs_d;
  logic signed [9:0] dx, dy;
  logic [9:0] ax, ay;
  logic dim, vs_prev, tick, step;
  logic [CW-1:0] fcnt;
  logic [4:0] level;
  logic [3:0] prev_state;
  logic [11:0] c, cd;
  function automatic logic [3:0] fade(input logic [3:0] ch, input logic [4:0] lv);
    logic [8:0] p;
    p = {5'd0, ch} * {4'd0, lv};
    return 4'(p >> 4);
  endfunction
  always_comb begin
    dx = (h_cnt >> 1) - {1'b0, player_x};
    dy = (v_cnt >> 1) - {1'b0, player_y};
    ax = dx[9] ? -dx : dx;
    ay = dy[9] ? -dy : dy;
    dim = is_dark && (ax > {1'b0, DARK_HALF} || ay > {1'b0, DARK_HALF});
    tick = vs_prev && !vsync_in;
    step = tick && fcnt == CW'(FRM_STEP - 1);
    c = (nb_d[D-1] && mem_rdata != KEY_COLOR) ? mem_rdata : BG_COLOR;
    cd = dim_d[D-1] ? {2'b0, c[11:10], 2'b0, c[7:6], 2'b0, c[3:2]} : c;
  end
  // The last sideband stage is the output register itself, giving MEM_LAT+2 total latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr <= '0;
      v_d <= '0;
      nb_d <= '0;
      dim_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      mem_addr <= pixel_addr;
      v_d <= {v_d[D-2:0], valid_in};
      nb_d <= {nb_d[D-2:0], not_blank};
      dim_d <= {dim_d[D-2:0], dim};
      hs_d <= {hs_d[D-2:0], hsync_in};
      vs_d <= {vs_d[D-2:0], vsync_in};
      vga_r <= v_d[D-1] ? fade(cd[11:8], level) : 4'd0;
      vga_g <= v_d[D-1] ? fade(cd[7:4], level) : 4'd0;
      vga_b <= v_d[D-1] ? fade(cd[3:0], level) : 4'd0;
      hsync_out <= hs_d[D-1];
      vsync_out <= vs_d[D-1];
    end
  end
  // Frame counter updates first; any FSM transition below overrides it with a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm <= IDLE;
      level <= 5'd16;
      prev_state <= state_in;
      fcnt <= '0;
      vs_prev <= 1'b1;
      fade_busy <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (tick) fcnt <= step ? '0 : fcnt + 1'b1;
      case (fsm)
        IDLE:
          if (state_in != prev_state) begin
            fsm <= FADE_OUT;
            fcnt <= '0;
            fade_busy <= 1'b1;
          end
        FADE_OUT:
          if (level == 5'd0) begin
            fsm <= HOLD;
            fcnt <= '0;
          end else if (step) level <= level - 5'd1;
        HOLD:
          if (tick) begin
            prev_state <= state_in;
            fsm <= FADE_IN;
            fcnt <= '0;
          end
        FADE_IN:
          if (state_in != prev_state) begin
            fsm <= FADE_OUT;
            fcnt <= '0;
          end else if (level == 5'd16) begin
            fsm <= IDLE;
            fcnt <= '0;
            fade_busy <= 1'b0;
          end else if (step) level <= level + 5'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_shader.sv
// tb_pixel_shader: directed + randomized bench with a frame-level reference model of the shader
module tb_pixel_shader;
  localparam int MEM_LAT = 2;
  localparam int L = MEM_LAT + 2;
  localparam int STEP = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic valid_in, hsync_in, vsync_in, not_blank, is_dark;
  logic [9:0] h_cnt, v_cnt;
  logic [16:0] pixel_addr, mem_addr;
  logic [8:0] player_x, player_y;
  logic [3:0] state_in, vga_r, vga_g, vga_b;
  logic [11:0] mem_rdata;
  logic hsync_out, vsync_out, fade_busy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pixel_shader #(.MEM_LAT(MEM_LAT), .FRM_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .pixel_addr(pixel_addr), .not_blank(not_blank),
    .is_dark(is_dark), .player_x(player_x), .player_y(player_y), .state_in(state_in),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .fade_busy(fade_busy)
  );
  logic [11:0] rom [256];
  logic [11:0] rq [MEM_LAT];
  always @(posedge clk) begin
    rq[0] <= rom[mem_addr[7:0]];
    for (int i = 1; i < MEM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign mem_rdata = rq[MEM_LAT-1];
  typedef struct {bit v; bit nb; bit dim; bit hs; bit vs; logic [11:0] c;} px_t;
  px_t hist [L];
  int lvl, base, n, prev, phase;
  bit busy, vsp, exp_hs, exp_vs;
  logic [11:0] exp_rgb;
  logic [16:0] exp_addr;
  function automatic bit dim_of(bit dk, int h, int v, int px, int py);
    int dx = h / 2 - px;
    int dy = v / 2 - py;
    return dk && ((dx < 0 ? -dx : dx) > 40 || (dy < 0 ? -dy : dy) > 40);
  endfunction
  function automatic logic [11:0] shade(px_t q, int lv);
    int ch [3];
    logic [11:0] r;
    if (!q.v) return 12'h000;
    r = (q.nb && q.c != 12'h0F0) ? q.c : 12'h000;
    for (int i = 0; i < 3; i++) begin
      ch[i] = int'(r[11-4*i -: 4]);
      if (q.dim) ch[i] = ch[i] / 4;
      ch[i] = ch[i] * lv / 16;
    end
    return {4'(ch[0]), 4'(ch[1]), 4'(ch[2])};
  endfunction
  // Fade phases: 0 idle, 1 fading out, 2 holding dark, 3 fading in; level = base -/+ ticks/STEP.
  always @(posedge clk) begin : model
    px_t p;
    bit tick;
    if (!rst) begin
      lvl = 16; base = 16; n = 0; phase = 0; busy = 0; prev = int'(state_in); vsp = 1;
      for (int i = 0; i < L; i++) hist[i] = '{v: 0, nb: 0, dim: 0, hs: 1, vs: 1, c: 12'h000};
      exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1; exp_addr = '0;
    end else begin
      p.v = valid_in; p.nb = not_blank; p.hs = hsync_in; p.vs = vsync_in;
      p.c = rom[pixel_addr[7:0]];
      p.dim = dim_of(is_dark, int'(h_cnt), int'(v_cnt), int'(player_x), int'(player_y));
      for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = p;
      exp_rgb = shade(hist[L-1], lvl);
      exp_hs = hist[L-1].hs;
      exp_vs = hist[L-1].vs;
      exp_addr = pixel_addr;
      tick = vsp && !vsync_in;
      vsp = vsync_in;
      case (phase)
        0: if (int'(state_in) != prev) begin phase = 1; base = lvl; n = 0; busy = 1; end
        1: if (lvl == 0) begin phase = 2; n = 0; end
           else if (tick) begin n++; lvl = base - n / STEP; if (lvl < 0) lvl = 0; end
        2: if (tick) begin prev = int'(state_in); phase = 3; base = lvl; n = 0; end
        3: if (int'(state_in) != prev) begin phase = 1; base = lvl; n = 0; end
           else if (lvl == 16) begin phase = 0; busy = 0; end
           else if (tick) begin n++; lvl = base + n / STEP; if (lvl > 16) lvl = 16; end
        default: ;
      endcase
    end
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_rgb});
    chk("hsync", {31'd0, hsync_out}, {31'd0, exp_hs});
    chk("vsync", {31'd0, vsync_out}, {31'd0, exp_vs});
    chk("busy", {31'd0, fade_busy}, {31'd0, busy});
    chk("mem_addr", {15'd0, mem_addr}, {15'd0, exp_addr});
  endtask
  task automatic rnd_px();
    valid_in = $urandom_range(0, 7) != 0;
    not_blank = $urandom_range(0, 5) != 0;
    is_dark = 1'($urandom_range(0, 1));
    h_cnt = 10'($urandom_range(0, 639));
    v_cnt = 10'($urandom_range(0, 479));
    player_x = 9'($urandom_range(0, 319));
    player_y = 9'($urandom_range(0, 239));
    pixel_addr = 17'($urandom);
  endtask
  task automatic frames(int nf);
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < 8; k++) begin
        vsync_in = k != 0;
        hsync_in = (k % 4) != 3;
        rnd_px();
        cyc();
      end
  endtask
  task automatic pix_lit(string tag, logic [16:0] a, bit nb, bit dk, bit hs, int h, int v, int px, int py,
                         logic [11:0] want);
    valid_in = 1; not_blank = nb; is_dark = dk; hsync_in = hs; pixel_addr = a;
    h_cnt = 10'(h); v_cnt = 10'(v); player_x = 9'(px); player_y = 9'(py);
    cyc();
    valid_in = 0; hsync_in = 1; pixel_addr = 17'($urandom);
    repeat (L - 1) cyc();
    chk(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, want});
    chk({tag, "_hs"}, {31'd0, hsync_out}, {31'd0, hs});
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    rom[0] = 12'h0F0; rom[1] = 12'hFFF; rom[2] = 12'hABC; rom[3] = 12'h0F0;
    valid_in = 0; not_blank = 0; is_dark = 0; hsync_in = 1; vsync_in = 1;
    h_cnt = '0; v_cnt = '0; pixel_addr = '0; player_x = '0; player_y = '0; state_in = 4'd0;
    repeat (3) cyc();
    chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
    chk("rst_sync", {30'd0, hsync_out, vsync_out}, 32'h3);
    chk("rst_busy", {31'd0, fade_busy}, 32'h0);
    rst = 1;
    cyc();
    pix_lit("lat_abc", 17'd2, 1, 0, 0, 10, 10, 0, 0, 12'hABC);
    pix_lit("key", 17'd0, 1, 0, 1, 10, 10, 0, 0, 12'h000);
    pix_lit("blank", 17'd1, 0, 0, 1, 10, 10, 0, 0, 12'h000);
    pix_lit("dark_out", 17'd1, 1, 1, 1, 400, 200, 100, 100, 12'h333);
    pix_lit("dark_in", 17'd1, 1, 1, 0, 200, 200, 100, 100, 12'hFFF);
    frames(20);
    state_in = 4'd2;
    for (int i = 0; i < 40 && !(phase == 1 && lvl == 8); i++) frames(1);
    chk("reach_lvl8", {31'd0, phase == 1 && lvl == 8}, 32'h1);
    vsync_in = 1;
    pix_lit("lvl8", 17'd1, 1, 0, 1, 10, 10, 0, 0, 12'h777);
    chk("busy_fade", {31'd0, fade_busy}, 32'h1);
    for (int i = 0; i < 100 && !(phase == 3 && lvl == 10); i++) frames(1);
    chk("reach_in10", {31'd0, phase == 3 && lvl == 10}, 32'h1);
    state_in = 4'd5;
    frames(3);
    state_in = 4'd7;
    frames(2);
    for (int i = 0; i < 200 && phase != 0; i++) frames(1);
    chk("fade_done", {31'd0, fade_busy}, 32'h0);
    frames(6);
    chk("no_restart", {31'd0, fade_busy}, 32'h0);
    state_in = 4'd9;
    frames(6);
    chk("busy_pre_rst", {31'd0, fade_busy}, 32'h1);
    rst = 0;
    cyc();
    chk("mid_rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
    chk("mid_rst_sync", {30'd0, hsync_out, vsync_out}, 32'h3);
    chk("mid_rst_busy", {31'd0, fade_busy}, 32'h0);
    rst = 1;
    vsync_in = 1;
    pix_lit("post_rst", 17'd1, 1, 0, 1, 10, 10, 0, 0, 12'hFFF);
    frames(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
